// File: rtl/useq_pkg.sv
// Shared types and constants for the multicycle micro-op sequencer.
// Optional XCHGM expansion is enabled by defining USEQ_XCHGM_EN.
package useq_pkg;

    localparam logic [5:0] OP_SWP   = 6'b111111;
    localparam logic [5:0] OP_XCHGM = 6'b111110;

    localparam logic [3:0] EXEC_ADD  = 4'b0000;
    localparam logic [3:0] EXEC_SWP1 = 4'b1100;
    localparam logic [3:0] EXEC_SWP2 = 4'b1101;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_FIRST  = 2'b01;
    localparam logic [1:0] SEL_SECOND = 2'b10;
    localparam logic [1:0] SEL_TEMP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWP_A = 3'd1,
        S_SWP_B = 3'd2
`ifdef USEQ_XCHGM_EN
        ,
        S_MX_LD = 3'd3,
        S_MX_ST = 3'd4,
        S_MX_WB = 3'd5
`endif
    } state_e;

    typedef struct packed {
        logic [3:0] exec_cmd;
        logic [1:0] swp_sel;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       freeze;
        logic       last;
    } uop_t;

    // First micro-op state for an opcode; S_IDLE means "not sequenced".
    function automatic state_e start_state(input logic [5:0] op);
        start_state = S_IDLE;
        if (op == OP_SWP)
            start_state = S_SWP_A;
`ifdef USEQ_XCHGM_EN
        if (op == OP_XCHGM)
            start_state = S_MX_LD;
`endif
    endfunction

    function automatic state_e seq_next(input state_e s);
        seq_next = S_IDLE;
        unique case (s)
            S_SWP_A: seq_next = S_SWP_B;
`ifdef USEQ_XCHGM_EN
            S_MX_LD: seq_next = S_MX_ST;
            S_MX_ST: seq_next = S_MX_WB;
`endif
            default: seq_next = S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_uop_sequencer_if.sv
// ID-stage bundle between the pipeline and the micro-op sequencer.
// Carries the XCHGM enables too; they stay 0 unless USEQ_XCHGM_EN is set.
interface multicycle_uop_sequencer_if;

    logic        id_valid;
    logic [5:0]  opcode;
    logic        hazard_stall;
    logic        flush;

    logic        freeze;
    logic        seq_active;
    logic        uop_valid;
    logic [3:0]  exec_cmd;
    logic [1:0]  swp_sel;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [15:0] seq_done_cnt;

    modport master (
        output id_valid, opcode, hazard_stall, flush,
        input  freeze, seq_active, uop_valid, exec_cmd, swp_sel,
        input  wb_en, mem_r_en, mem_w_en, seq_done_cnt
    );

    modport slave (
        input  id_valid, opcode, hazard_stall, flush,
        output freeze, seq_active, uop_valid, exec_cmd, swp_sel,
        output wb_en, mem_r_en, mem_w_en, seq_done_cnt
    );

endinterface

// File: rtl/useq_uop_decode.sv
// State-to-control-bundle decoder for the micro-op sequencer.
// MX_* rows exist only when USEQ_XCHGM_EN is defined.
module useq_uop_decode
    import useq_pkg::*;
(
    input  state_e state,
    output uop_t   uop
);

    always_comb begin
        uop          = '0;
        uop.exec_cmd = EXEC_ADD;
        uop.swp_sel  = SEL_NONE;
        unique case (state)
            S_SWP_A: begin
                uop.exec_cmd = EXEC_SWP1;
                uop.swp_sel  = SEL_FIRST;
                uop.wb_en    = 1'b1;
                uop.freeze   = 1'b1;
            end
            S_SWP_B: begin
                uop.exec_cmd = EXEC_SWP2;
                uop.swp_sel  = SEL_SECOND;
                uop.wb_en    = 1'b1;
                uop.last     = 1'b1;
            end
`ifdef USEQ_XCHGM_EN
            S_MX_LD: begin
                uop.swp_sel  = SEL_TEMP;
                uop.mem_r_en = 1'b1;
                uop.freeze   = 1'b1;
            end
            S_MX_ST: begin
                uop.mem_w_en = 1'b1;
                uop.freeze   = 1'b1;
            end
            S_MX_WB: begin
                uop.swp_sel  = SEL_TEMP;
                uop.wb_en    = 1'b1;
                uop.last     = 1'b1;
            end
`endif
            default: begin
                uop.exec_cmd = EXEC_ADD;
                uop.swp_sel  = SEL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_uop_sequencer.sv
// Expands multi-cycle opcodes (SWP; XCHGM with USEQ_XCHGM_EN) into micro-ops,
// freezing IF/ID and overriding the ID control bundle while a sequence runs.
module multicycle_uop_sequencer
    import useq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_uop_sequencer_if.slave bus
);

    state_e      state_q;
    state_e      state_d;
    state_e      first;
    uop_t        uop;
    logic [15:0] cnt_q;
    logic        busy;
    logic        start;
    logic        live;
    logic        done;

    useq_uop_decode u_dec (
        .state (state_q),
        .uop   (uop)
    );

    assign first = start_state(bus.opcode);
    assign busy  = (state_q != S_IDLE);

    // rst_n gates start so every output reads 0 while reset is held.
    assign start = rst_n & ~busy & bus.id_valid
                 & ~bus.hazard_stall & ~bus.flush
                 & (first != S_IDLE);

    assign live = busy & ~bus.hazard_stall & ~bus.flush;
    assign done = live & uop.last;

    always_comb begin
        state_d = state_q;
        if (bus.flush)
            state_d = S_IDLE;
        else if (start)
            state_d = first;
        else if (busy && !bus.hazard_stall)
            state_d = seq_next(state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (done)
            cnt_q <= cnt_q + 16'd1;
    end

    // A flushed micro-op releases the freeze so IF/ID can take the redirect.
    assign bus.freeze = busy
                      ? (~bus.flush & (uop.freeze | bus.hazard_stall))
                      : start;

    assign bus.seq_active   = busy;
    assign bus.uop_valid    = live;
    assign bus.exec_cmd     = uop.exec_cmd;
    assign bus.swp_sel      = uop.swp_sel;
    assign bus.wb_en        = uop.wb_en & live;
    assign bus.mem_r_en     = uop.mem_r_en & live;
    assign bus.mem_w_en     = uop.mem_w_en & live;
    assign bus.seq_done_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_uop_sequencer.sv
// Directed bench for multicycle_uop_sequencer; builds with or without
// USEQ_XCHGM_EN and checks the matching XCHGM behaviour.
module tb_multicycle_uop_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_cnt = 0;
    int   busy_cyc = 0;

    multicycle_uop_sequencer_if bus ();

    multicycle_uop_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bundle order: freeze seq_active uop_valid exec swp_sel wb mr mw
    task automatic cb(input string tag, input logic fr, input logic sa,
                      input logic uv, input logic [3:0] ec,
                      input logic [1:0] ss, input logic wb,
                      input logic mr, input logic mw);
        logic [11:0] got;
        got = {bus.freeze, bus.seq_active, bus.uop_valid, bus.exec_cmd,
               bus.swp_sel, bus.wb_en, bus.mem_r_en, bus.mem_w_en};
        chk(tag, {20'd0, got}, {20'd0, fr, sa, uv, ec, ss, wb, mr, mw});
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic st, input logic fl);
        @(negedge clk);
        bus.id_valid     = v;
        bus.opcode       = op;
        bus.hazard_stall = st;
        bus.flush        = fl;
        #1;
        if (bus.freeze || bus.seq_active)
            busy_cyc++;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.id_valid     = 1'b0;
        bus.opcode       = 6'd0;
        bus.hazard_stall = 1'b0;
        bus.flush        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        cb("rst_out", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("rst_cnt", 32'(bus.seq_done_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single SWP
        drive(1, 6'h3F, 0, 0); cb("swp_start", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("swp_a", 1, 1, 1, 4'hC, 2'd1, 1, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("swp_b", 0, 1, 1, 4'hD, 2'd2, 1, 0, 0);
        exp_cnt++;
        drive(0, 6'h00, 0, 0); cb("swp_idle", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("swp_cnt", 32'(bus.seq_done_cnt), exp_cnt);

        // stall in SWP_A twice, then in SWP_B once
        drive(1, 6'h3F, 0, 0); cb("st_start", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 1, 0); cb("st_a1", 1, 1, 0, 4'hC, 2'd1, 0, 0, 0);
        drive(1, 6'h3F, 1, 0); cb("st_a2", 1, 1, 0, 4'hC, 2'd1, 0, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("st_a3", 1, 1, 1, 4'hC, 2'd1, 1, 0, 0);
        drive(1, 6'h3F, 1, 0); cb("st_b1", 1, 1, 0, 4'hD, 2'd2, 0, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("st_b2", 0, 1, 1, 4'hD, 2'd2, 1, 0, 0);
        chk("st_cnt_hold", 32'(bus.seq_done_cnt), exp_cnt);
        exp_cnt++;
        drive(0, 6'h00, 0, 0); cb("st_idle", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("st_cnt", 32'(bus.seq_done_cnt), exp_cnt);

        // flush in SWP_A
        drive(1, 6'h3F, 0, 0); cb("fl_start", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 0, 1); cb("fl_a", 0, 1, 0, 4'hC, 2'd1, 0, 0, 0);
        drive(0, 6'h00, 0, 0); cb("fl_idle", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("fl_cnt", 32'(bus.seq_done_cnt), exp_cnt);

        // stall or flush in IDLE block the start
        drive(1, 6'h3F, 1, 0); cb("idle_stall", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 0, 1); cb("idle_flush", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(0, 6'h00, 0, 0); cb("idle_after", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);

        // back-to-back SWPs then ADD
        busy_cyc = 0;
        drive(1, 6'h3F, 0, 0); cb("bb_s1", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("bb_a1", 1, 1, 1, 4'hC, 2'd1, 1, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("bb_b1", 0, 1, 1, 4'hD, 2'd2, 1, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("bb_s2", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("bb_a2", 1, 1, 1, 4'hC, 2'd1, 1, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("bb_b2", 0, 1, 1, 4'hD, 2'd2, 1, 0, 0);
        exp_cnt += 2;
        drive(1, 6'h01, 0, 0); cb("bb_add", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("bb_cycles", busy_cyc, 6);
        chk("bb_cnt", 32'(bus.seq_done_cnt), exp_cnt);

`ifdef USEQ_XCHGM_EN
        drive(1, 6'h3E, 0, 0); cb("mx_start", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3E, 0, 0); cb("mx_ld", 1, 1, 1, 4'h0, 2'd3, 0, 1, 0);
        drive(1, 6'h3E, 0, 0); cb("mx_st", 1, 1, 1, 4'h0, 2'd0, 0, 0, 1);
        drive(1, 6'h3E, 0, 0); cb("mx_wb", 0, 1, 1, 4'h0, 2'd3, 1, 0, 0);
        exp_cnt++;
        drive(0, 6'h00, 0, 0); cb("mx_idle", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        chk("mx_cnt", 32'(bus.seq_done_cnt), exp_cnt);
`else
        drive(1, 6'h3E, 0, 0); cb("mx_off1", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3E, 0, 0); cb("mx_off2", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(0, 6'h00, 0, 0);
        chk("mx_off_cnt", 32'(bus.seq_done_cnt), exp_cnt);
`endif

        // counter wrap: preload 0xFFFE, then two more sequences
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        bus.id_valid = 1'b1;
        bus.opcode   = 6'h3F;
        #1;
        cb("wr_start", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        @(negedge clk);
        release dut.cnt_q;
        #1;
        drive(1, 6'h3F, 0, 0); cb("wr_b1", 0, 1, 1, 4'hD, 2'd2, 1, 0, 0);
        drive(0, 6'h00, 0, 0);
        chk("wr_ffff", 32'(bus.seq_done_cnt), 32'h0000_FFFF);
        drive(1, 6'h3F, 0, 0);
        drive(1, 6'h3F, 0, 0);
        drive(1, 6'h3F, 0, 0);
        drive(0, 6'h00, 0, 0);
        chk("wr_zero", 32'(bus.seq_done_cnt), 0);

        // reset mid-SWP_A, then restart
        drive(1, 6'h3F, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("rm_a", 1, 1, 1, 4'hC, 2'd1, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        cb("rm_out", 0, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cb("rm_restart", 1, 0, 0, 4'h0, 2'd0, 0, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("rm_swp_a", 1, 1, 1, 4'hC, 2'd1, 1, 0, 0);
        drive(1, 6'h3F, 0, 0); cb("rm_swp_b", 0, 1, 1, 4'hD, 2'd2, 1, 0, 0);
        drive(0, 6'h00, 0, 0);
        chk("rm_cnt", 32'(bus.seq_done_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
